// File: rtl/y_trace_pkg.sv
// Shared encodings for the trace buffer: FSM state and capture mode constants.
package y_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_e;

  localparam logic [1:0] MODE_WRAP      = 2'b00;
  localparam logic [1:0] MODE_STOP_FULL = 2'b01;
  localparam logic [1:0] MODE_TRIG      = 2'b10;

  // The unused encoding 11 behaves like wrap mode.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_WRAP : m;
  endfunction

endpackage

// File: rtl/y_trace_mem.sv
// Record storage: one synchronous write port, one asynchronous read port.
module y_trace_mem #(
  parameter int DW    = 96,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DW-1:0]            rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/y_trace_buf.sv
// Trace capture buffer: circular record store with wrap, stop-when-full and
// trigger/post-count capture modes, drained through a ready/valid read port.
module y_trace_buf
  import y_trace_pkg::*;
#(
  parameter int W     = 32,
  parameter int CH    = 3,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   INTn,
  input  logic                   arm,
  input  logic                   stop,
  input  logic [1:0]             mode,
  input  logic                   trig,
  input  logic [$clog2(DEPTH):0] post_cnt,
  input  logic                   cap_en,
  input  logic [CH*W-1:0]        cap_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [CH*W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic [1:0]             state,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  trace_state_e  st;
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] cnt, remaining;
  logic          ovf;
  logic [1:0]    m;
  logic          full, wr, pop;

  assign m    = norm_mode(mode);
  assign full = (cnt == FULL_CNT);

  // A POST window that is already satisfied takes no more records, and
  // stop-when-full never overwrites.
  always_comb begin
    wr = 1'b0;
    if ((st == ST_ARMED || st == ST_POST) && cap_en)
      wr = !(st == ST_POST && remaining == '0) && !(m == MODE_STOP_FULL && full);
  end

  assign rd_valid = (st == ST_DONE) && (cnt != '0);
  assign pop      = rd_valid && rd_ready;

  y_trace_mem #(.DW(CH*W), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (wr),
    .waddr (wptr),
    .wdata (cap_data),
    .raddr (rptr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!INTn) begin
      st        <= ST_IDLE;
      cnt       <= '0;
      wptr      <= '0;
      rptr      <= '0;
      remaining <= '0;
      ovf       <= 1'b0;
    end else begin
      if (wr) begin
        wptr <= wptr + 1'b1;
        if (full) begin
          rptr <= rptr + 1'b1;
          ovf  <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      case (st)
        ST_IDLE: begin
          if (arm) begin
            st        <= ST_ARMED;
            cnt       <= '0;
            wptr      <= '0;
            rptr      <= '0;
            remaining <= '0;
            ovf       <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (stop)
            st <= ST_DONE;
          else if (m == MODE_STOP_FULL && (full || (wr && cnt == LAST_CNT)))
            st <= ST_DONE;
          else if (m == MODE_TRIG && trig) begin
            st        <= ST_POST;
            remaining <= post_cnt;
          end
        end
        ST_POST: begin
          if (stop || remaining == '0)
            st <= ST_DONE;
          else if (wr) begin
            remaining <= remaining - 1'b1;
            if (remaining == ONE) st <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (arm) begin
            st        <= ST_ARMED;
            cnt       <= '0;
            wptr      <= '0;
            rptr      <= '0;
            remaining <= '0;
            ovf       <= 1'b0;
          end else if (cnt == '0) begin
            st <= ST_IDLE;
          end else if (pop) begin
            rptr <= rptr + 1'b1;
            cnt  <= cnt - 1'b1;
            if (cnt == ONE) st <= ST_IDLE;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  assign count    = cnt;
  assign state    = st;
  assign overflow = ovf;

endmodule

// File: tb/tb_y_trace_buf.sv
// Bench for y_trace_buf: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_y_trace_buf;

  localparam int W = 32, CH = 3, DEPTH = 4;
  localparam int DW = CH * W;

  logic          clk = 1'b0;
  logic          INTn, arm, stop, trig, cap_en, rd_ready, rd_valid, overflow;
  logic [1:0]    mode, state;
  logic [2:0]    post_cnt, count;
  logic [DW-1:0] cap_data, rd_data;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  y_trace_buf #(.W(W), .CH(CH), .DEPTH(DEPTH)) dut (
    .clk(clk), .INTn(INTn), .arm(arm), .stop(stop), .mode(mode), .trig(trig),
    .post_cnt(post_cnt), .cap_en(cap_en), .cap_data(cap_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .count(count), .state(state), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rec(input int k);
    return {32'hC000_0000 + k, 32'hB000_0000 + k, 32'hA000_0000 + k};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue of records, oldest first.
  logic [DW-1:0] q[$];
  int  mst = 0;
  int  mrem = 0;
  bit  movf = 1'b0;

  always @(posedge clk) begin
    int  md;
    bit  take;
    md = (mode == 2'b11) ? 0 : int'(mode);
    if (!INTn) begin
      mst = 0; q.delete(); movf = 0; mrem = 0;
    end else begin
      case (mst)
        0: if (arm) begin mst = 1; q.delete(); movf = 0; mrem = 0; end
        1, 2: begin
          take = cap_en;
          if (mst == 2 && mrem == 0) take = 0;
          if (md == 1 && q.size() == DEPTH) take = 0;
          if (take) begin
            if (q.size() == DEPTH) begin void'(q.pop_front()); movf = 1; end
            q.push_back(cap_data);
          end
          if (stop) mst = 3;
          else if (mst == 1) begin
            if (md == 1 && q.size() == DEPTH) mst = 3;
            else if (md == 2 && trig) begin mst = 2; mrem = int'(post_cnt); end
          end else begin
            if (mrem == 0) mst = 3;
            else if (take) begin mrem--; if (mrem == 0) mst = 3; end
          end
        end
        default: begin
          if (arm) begin mst = 1; q.delete(); movf = 0; mrem = 0; end
          else if (q.size() == 0) mst = 0;
          else if (rd_ready) begin void'(q.pop_front()); if (q.size() == 0) mst = 0; end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_state", DW'(state), DW'(mst));
      chk("m_count", DW'(count), DW'(q.size()));
      chk("m_overflow", DW'(overflow), DW'(movf));
      chk("m_rd_valid", DW'(rd_valid), DW'(mst == 3 && q.size() != 0));
      if (mst == 3 && q.size() != 0) chk("m_rd_data", rd_data, q[0]);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_arm(input logic [1:0] m);
    mode = m; arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic cap(input int k);
    cap_en = 1'b1; cap_data = rec(k); tick(); cap_en = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  // Pops n records expecting rec(first)..rec(first+n-1), then IDLE.
  task automatic drain(input string name, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      chk({name, "_valid"}, DW'(rd_valid), DW'(1));
      chk({name, "_data"}, rd_data, rec(first + i));
      rd_ready = 1'b1; tick();
    end
    rd_ready = 1'b0;
    chk({name, "_idle"}, DW'(state), DW'(0));
  endtask

  initial begin
    INTn = 1'b0; arm = 0; stop = 0; trig = 0; cap_en = 0; rd_ready = 0;
    mode = 2'b00; post_cnt = '0; cap_data = '0;
    tick(); tick();
    chk("rst_state", DW'(state), DW'(0));
    chk("rst_count", DW'(count), DW'(0));
    chk("rst_valid", DW'(rd_valid), DW'(0));
    chk("rst_ovf", DW'(overflow), DW'(0));
    chk_en = 1'b1;
    INTn = 1'b1;

    // IDLE ignores captures
    cap(99);
    chk("idle_count", DW'(count), DW'(0));

    // stop-when-full
    do_arm(2'b01);
    for (int k = 1; k <= 4; k++) cap(k);
    chk("sf_state", DW'(state), DW'(3));
    chk("sf_count", DW'(count), DW'(4));
    cap(5);
    chk("sf_count_after", DW'(count), DW'(4));
    drain("sf", 1, 4);

    // wrap (mode 11 aliases 00)
    do_arm(2'b11);
    for (int k = 1; k <= 6; k++) cap(k);
    do_stop();
    chk("wr_state", DW'(state), DW'(3));
    chk("wr_count", DW'(count), DW'(4));
    chk("wr_ovf", DW'(overflow), DW'(1));
    drain("wr", 3, 4);

    // trigger with post_cnt=2
    post_cnt = 3'd2;
    do_arm(2'b10);
    for (int k = 1; k <= 3; k++) cap(k);
    trig = 1'b1; cap(4); trig = 1'b0;
    chk("tr_post", DW'(state), DW'(2));
    cap(5);
    chk("tr_post2", DW'(state), DW'(2));
    cap(6);
    chk("tr_state", DW'(state), DW'(3));
    chk("tr_ovf", DW'(overflow), DW'(1));
    chk("tr_count", DW'(count), DW'(4));
    drain("tr", 3, 4);

    // backpressure
    do_arm(2'b00);
    for (int k = 1; k <= 3; k++) cap(k);
    do_stop();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_data", rd_data, rec(1));
      chk("bp_count", DW'(count), DW'(3));
    end
    drain("bp", 1, 3);

    // reset during POST, then post_cnt=0
    post_cnt = 3'd3;
    do_arm(2'b10);
    trig = 1'b1; cap(1); trig = 1'b0;
    chk("rs_post", DW'(state), DW'(2));
    INTn = 1'b0; tick(); INTn = 1'b1;
    chk("rs_state", DW'(state), DW'(0));
    chk("rs_count", DW'(count), DW'(0));
    chk("rs_valid", DW'(rd_valid), DW'(0));
    post_cnt = 3'd0;
    do_arm(2'b10);
    trig = 1'b1; cap(7); trig = 1'b0;
    tick();
    chk("p0_state", DW'(state), DW'(3));
    chk("p0_count", DW'(count), DW'(1));
    drain("p0", 7, 1);

    // stop beats trig
    post_cnt = 3'd2;
    do_arm(2'b10);
    cap(1);
    stop = 1'b1; trig = 1'b1; tick(); stop = 1'b0; trig = 1'b0;
    chk("st_state", DW'(state), DW'(3));
    drain("st", 1, 1);

    // arm in DONE discards contents; DONE with count=0 returns to IDLE
    do_arm(2'b00);
    cap(1); cap(2);
    do_stop();
    do_arm(2'b00);
    chk("ra_state", DW'(state), DW'(1));
    chk("ra_count", DW'(count), DW'(0));
    do_stop();
    chk("ra_done", DW'(state), DW'(3));
    tick();
    chk("ra_idle", DW'(state), DW'(0));

    tick();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
